// File: rtl/vector_linear_param_if.sv
// Request, memory-read and result-stream signals of the vector linear layer.
// The slave modport is the engine's view; the master modport is the view of its environment.
interface vector_linear_param_if #(
  parameter int IN_LEN  = 32,
  parameter int OUT_LEN = 96,
  parameter int DW      = 32,
  parameter int AW      = 32
);
  localparam int IDXW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;

  logic            valid;
  logic            ready;
  logic [DW-1:0]   vector [IN_LEN];
  logic [AW-1:0]   weight_start_addr;
  logic [AW-1:0]   bias_start_addr;
  logic            relu_en;
  logic            mem_rd_en;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rd_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   result;
  logic [IDXW-1:0] result_idx;
  logic            done;

  modport slave (
    input  valid, vector, weight_start_addr, bias_start_addr, relu_en,
    output ready,
    output mem_rd_en, mem_addr,
    input  mem_rd_data,
    output out_valid, result, result_idx, done,
    input  out_ready
  );

  modport master (
    output valid, vector, weight_start_addr, bias_start_addr, relu_en,
    input  ready,
    input  mem_rd_en, mem_addr,
    output mem_rd_data,
    input  out_valid, result, result_idx, done,
    output out_ready
  );
endinterface

// File: rtl/vector_linear_param.sv
// Fixed-point linear layer y[r] = sat((sum_k x[k]*W[r][k]) >>> FRAC + b[r]) with optional ReLU,
// fetching weights/biases through one 1-cycle-latency read port and streaming rows out.
module vector_linear_param #(
  parameter int IN_LEN  = 32,
  parameter int OUT_LEN = 96,
  parameter int DW      = 32,
  parameter int FRAC    = 16,
  parameter int AW      = 32
) (
  input logic clk,
  input logic rst,
  vector_linear_param_if.slave bus
);
  localparam int IDXW = (OUT_LEN > 1) ? $clog2(OUT_LEN) : 1;
  localparam int KW   = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int ACCW = 2*DW + $clog2(IN_LEN) + 1;
  localparam int VW   = ACCW + 1;
  localparam logic signed [VW-1:0] MAXV = $signed({{(VW-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [VW-1:0] MINV = $signed({{(VW-DW+1){1'b1}}, {(DW-1){1'b0}}});

  typedef enum logic [2:0] {IDLE, BIAS, MAC, OUT, FIN} state_t;
  state_t state, state_next;

  logic signed [DW-1:0]   vec_q [IN_LEN];
  logic [AW-1:0]          wbase, bbase, row_base;
  logic                   relu_q;
  logic [IDXW-1:0]        r;
  logic [KW-1:0]          k, kd;
  logic                   wpend, bpend;
  logic signed [ACCW-1:0] acc;
  logic signed [DW-1:0]   bias_q;
  logic                   out_valid_q;
  logic [DW-1:0]          result_q;
  logic [IDXW-1:0]        idx_q;

  logic                   ready_c, done_c, rd_en_c;
  logic [AW-1:0]          addr_c;
  logic signed [DW-1:0]   rd_data, vec_sel;
  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] acc_sum, shifted;
  logic signed [VW-1:0]   val;
  logic [DW-1:0]          res_c;

  assign rd_data = bus.mem_rd_data;
  assign vec_sel = vec_q[kd];
  assign prod    = $signed({{DW{vec_sel[DW-1]}}, vec_sel}) * $signed({{DW{rd_data[DW-1]}}, rd_data});
  // Read data lags its strobe by a cycle, so the last weight is folded in during the first OUT cycle.
  assign acc_sum = wpend ? acc + $signed({{(ACCW-2*DW){prod[2*DW-1]}}, prod}) : acc;
  assign shifted = acc_sum >>> FRAC;
  assign val     = $signed({shifted[ACCW-1], shifted}) + $signed({{(VW-DW){bias_q[DW-1]}}, bias_q});

  always_comb begin
    res_c = val[DW-1:0];
    if (val > MAXV)      res_c = MAXV[DW-1:0];
    else if (val < MINV) res_c = MINV[DW-1:0];
    if (relu_q && val[VW-1]) res_c = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready_c    = 1'b0;
    done_c     = 1'b0;
    rd_en_c    = 1'b0;
    addr_c     = '0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.valid) state_next = BIAS;
      end
      BIAS: begin
        rd_en_c    = 1'b1;
        addr_c     = bbase + AW'(r);
        state_next = MAC;
      end
      MAC: begin
        rd_en_c = 1'b1;
        addr_c  = wbase + row_base + AW'(k);
        if (k == KW'(IN_LEN - 1)) state_next = OUT;
      end
      OUT: begin
        if (out_valid_q && bus.out_ready)
          state_next = (r == IDXW'(OUT_LEN - 1)) ? FIN : BIAS;
      end
      FIN: begin
        done_c     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < IN_LEN; i++) vec_q[i] <= '0;
      wbase       <= '0;
      bbase       <= '0;
      row_base    <= '0;
      relu_q      <= 1'b0;
      r           <= '0;
      k           <= '0;
      kd          <= '0;
      wpend       <= 1'b0;
      bpend       <= 1'b0;
      acc         <= '0;
      bias_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      idx_q       <= '0;
    end else begin
      wpend <= (state == MAC);
      bpend <= (state == BIAS);
      kd    <= k;
      if (bpend) bias_q <= rd_data;
      case (state)
        IDLE: if (bus.valid) begin
          for (int unsigned i = 0; i < IN_LEN; i++) vec_q[i] <= bus.vector[i];
          wbase    <= bus.weight_start_addr;
          bbase    <= bus.bias_start_addr;
          relu_q   <= bus.relu_en;
          r        <= '0;
          row_base <= '0;
        end
        BIAS: begin
          acc <= '0;
          k   <= '0;
        end
        MAC: begin
          acc <= acc_sum;
          k   <= k + 1'b1;
        end
        OUT: begin
          if (!out_valid_q) begin
            result_q    <= res_c;
            idx_q       <= r;
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (r != IDXW'(OUT_LEN - 1)) begin
              r        <= r + 1'b1;
              row_base <= row_base + AW'(IN_LEN);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready      = ready_c;
  assign bus.done       = done_c;
  assign bus.mem_rd_en  = rd_en_c;
  assign bus.mem_addr   = addr_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.result     = result_q;
  assign bus.result_idx = idx_q;
endmodule

// File: doc/vector_linear_param.md
Name: vector_linear_param

Overview:
- Parametrised fixed-point linear layer: computes y[r] = sat(((sum over k of x[k]*W[r][k]) >>> FRAC) + b[r]) for r = 0..OUT_LEN-1, with optional ReLU.
- Weights and biases are read from a shared word-addressed memory through a single read port.
- Results stream out one row at a time on a valid/ready handshake.
- Next-generation replacement for the fixed 32x96 vector-linear engine used in the RNN datapath.
- Adds configurable sizes, backpressure, saturation and an activation mode.

Parameters:
- IN_LEN, 32, input vector length (k range); must be >= 1.
- OUT_LEN, 96, number of output rows (r range); must be >= 1.
- DW, 32, data width of vector, weight, bias and result; signed two's complement.
- FRAC, 16, fractional bits (Q(DW-FRAC).FRAC format); must be < DW.
- AW, 32, memory word-address width.

Ports:
- clk  in  1  clock; the block has one clock.
- rst  in  1  reset; synchronous and active-high.
- valid  in  1  start request; accepted when valid && ready.
- vector  in  DW x IN_LEN  input vector, unpacked array; sampled on accept.
- weight_start_addr  in  AW  word address of W[0][0]; row-major layout, W[r][k] at weight_start_addr + r*IN_LEN + k.
- bias_start_addr  in  AW  word address of b[0]; b[r] at bias_start_addr + r.
- relu_en  in  1  sampled on accept; 1 = clamp negative results to 0.
- ready  out  1  high only in IDLE.
- mem_rd_en  out  1  read strobe.
- mem_addr  out  AW  read address, valid while mem_rd_en is high.
- mem_rd_data  in  DW  read data; returned exactly 1 cycle after the strobe.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- result  out  DW  y[r].
- result_idx  out  clog2(OUT_LEN)  row index r of the current result.
- done  out  1  one-cycle pulse after the last row is accepted.

Behaviour:
- Reset values: ready=1, done=0, out_valid=0, mem_rd_en=0, mem_addr=0, result=0, result_idx=0; FSM in IDLE.
- Reset mid-operation: abandon the current job immediately; discard any in-flight read data; no done pulse is issued.
- FSM states: IDLE -> BIAS -> MAC -> OUT -> (BIAS for the next row | FIN) -> IDLE.
- IDLE:
  - ready=1.
  - On valid, latch vector, both start addresses and relu_en; clear r; go to BIAS.
  - valid is ignored in every other state.
  - Inputs may change after the accept cycle.
- BIAS (1 cycle):
  - mem_rd_en=1, mem_addr = bias_start_addr + r; clear the accumulator.
  - Go to MAC with k=0.
- MAC (IN_LEN cycles):
  - Each cycle: mem_rd_en=1, mem_addr = weight_start_addr + r*IN_LEN + k; k++.
  - Bias data is captured in the first MAC cycle.
  - Each weight word returns 1 cycle after its strobe; accumulate acc += vector[k]*data.
  - Product width is 2*DW signed; acc width is 2*DW + clog2(IN_LEN) + 1, so the accumulator never overflows.
  - After the last strobe, go to OUT.
  - The last product is accumulated on the transition into OUT.
- OUT:
  - Compute val = (acc >>> FRAC) + sign-extended bias. The shift is arithmetic, i.e. floor, with no rounding.
  - Saturate val to [-2^(DW-1), 2^(DW-1)-1]; if relu_en and val < 0, val = 0.
  - Register val onto result with out_valid=1, result_idx=r.
  - result and result_idx hold stable while out_valid && !out_ready.
  - On out_ready: if r == OUT_LEN-1, go to FIN; else r++ and go to BIAS.
  - out_valid drops in the cycle after acceptance.
- FIN: done=1 for exactly one cycle; return to IDLE, where ready=1 in the following cycle.
- Address arithmetic wraps modulo 2^AW.
- Timing, with the accept cycle as cycle 0:
  - Bias strobe is in cycle 1; weight strobes are in cycles 2..IN_LEN+1.
  - First out_valid appears in cycle IN_LEN+3.
  - With out_ready held high, row period is IN_LEN+3 cycles.
  - done is high in cycle OUT_LEN*(IN_LEN+3)+1.
- mem_rd_en is 0 in IDLE, OUT and FIN; no read is ever issued while stalled on backpressure.

Test Plan:
- IN_LEN=4, OUT_LEN=3, FRAC=16; vector all 0x00010000, all W = 0x00010000, b = {0, 0x00010000, 0xFFFF0000}, out_ready=1 -> results 0x00040000, 0x00050000, 0x00030000 at idx 0,1,2. First out_valid in cycle 7, then in cycles 14 and 21; done pulses in cycle 22.
- Same config, weight_start_addr=0x100, bias_start_addr=0x200 -> memory address trace is exactly 0x200, 0x100..0x103, 0x201, 0x104..0x107, 0x202, 0x108..0x10B.
- Saturation: vector = W = 0x7FFFFFFF, b=0 -> every result 0x7FFFFFFF. Negate W -> every result 0x80000000.
- ReLU: expected raw result -0x00020000; relu_en=1 -> 0x00000000, relu_en=0 -> 0xFFFE0000. Also drive relu_en low right after accept -> behaviour follows the latched value.
- Backpressure: hold out_ready=0 for 5 cycles on row 1 -> result and result_idx are stable, no mem_rd_en, valid pulses are ignored; rows complete in order once out_ready rises.
- Reset mid-MAC of row 1 -> the next cycle shows ready=1 and out_valid=0 with no done pulse; a fresh job then produces correct results.
